// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates fetch and data ports onto one fixed-latency main memory.
// Define ARB_RR_EN for round-robin tie-breaking; otherwise the data port wins ties.
module mem_arbiter #(
  parameter int MEM_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic [15:0] i_rdata,
  output logic        i_done,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_done,
  output logic        d_err,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_err
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ALIGN_ERR} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic last_grant;
  logic wr_q;
  logic [15:0] addr_q, wdata_q, rdata_o;
  logic any_req, grant_d, lat_hit, done, err_o;
  assign any_req = i_req | d_req;
`ifdef ARB_RR_EN
  assign grant_d = d_req & (~i_req | ~last_grant);
`else
  assign grant_d = d_req;
`endif
  assign lat_hit = cnt == 4'(MEM_LAT);
  // last_grant doubles as the owner of the transaction in flight (1 = data port)
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      last_grant <= 1'b0;
      wr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (state == IDLE && any_req) begin
        last_grant <= grant_d;
        wr_q <= grant_d & d_wr;
        addr_q <= grant_d ? d_addr : i_addr;
        wdata_q <= grant_d ? d_wdata : '0;
      end
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = '0;
    case (state)
      IDLE: state_n = !any_req ? IDLE : (grant_d ? d_addr[0] : i_addr[0]) ? ALIGN_ERR : ISSUE;
      ISSUE: begin
        state_n = WAIT;
        cnt_n = 4'd1;
      end
      WAIT: begin
        state_n = lat_hit ? IDLE : WAIT;
        cnt_n = lat_hit ? 4'd0 : cnt + 4'd1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    mem_en = state == ISSUE;
    done = (state == WAIT && lat_hit) || state == ALIGN_ERR;
    err_o = state == ALIGN_ERR || mem_err;
    rdata_o = (state == ALIGN_ERR || wr_q) ? '0 : mem_rdata;
    i_done = done & ~last_grant;
    d_done = done & last_grant;
    i_err = i_done & err_o;
    d_err = d_done & err_o;
    i_rdata = i_done ? rdata_o : '0;
    d_rdata = d_done ? rdata_o : '0;
  end
  assign mem_wr = wr_q;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
  localparam int MEM_LAT = 4;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0;
  logic i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0, mem_err = 1'b0;
  logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic i_done, i_err, d_done, d_err, mem_en, mem_wr;
  int checks = 0, errors = 0, cyc = 0, nen = 0, ret_cyc = 0;
  bit ret_pend = 0, ret_e = 0, last_e = 0, err_next = 0, last_d = 0, ad = 0, won;
  logic [15:0] ret_d;
  logic [15:0] mem_m [logic [15:0]];

  mem_arbiter #(.MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_err(i_err),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; the memory model answers MEM_LAT cycles after each strobe
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    mem_rdata = 16'($urandom);
    mem_err = 1'($urandom);
    if (ret_pend && cyc == ret_cyc) begin
      mem_rdata = ret_d;
      mem_err = ret_e;
      ret_pend = 0;
    end
    if (mem_en) begin
      nen++;
      if (mem_wr) begin
        mem_m[mem_addr] = mem_wdata;
        ret_d = 16'($urandom);
      end else begin
        if (!mem_m.exists(mem_addr)) mem_m[mem_addr] = 16'($urandom);
        ret_d = mem_m[mem_addr];
      end
      ret_e = err_next || ($urandom_range(0, 7) == 0);
      err_next = 0;
      last_e = ret_e;
      ret_pend = 1;
      ret_cyc = cyc + MEM_LAT;
    end
    #1;
  endtask

  function automatic logic [79:0] outs();
    return {10'd0, mem_en, mem_wr, mem_addr, mem_wdata, i_done, d_done, i_err, d_err, i_rdata, d_rdata};
  endfunction

  task automatic reset_dut();
    rst = 0;
    i_req = 0;
    d_req = 0;
    step();
    step();
    chk("reset_outputs", outs(), 80'd0);
    rst = 1;
    ret_pend = 0;
    last_d = 0;
  endtask

  // Wait for the next completion and compare it with what the arbitration rules predict
  task automatic serve(input bit after_done, output bit won_d);
    bit wd, w, mis;
    logic [15:0] a, exp_rd;
    int exp_n, n;
    wd = d_req && (!i_req || !RR || !last_d);
    a = wd ? d_addr : i_addr;
    w = wd && d_wr;
    mis = a[0];
    exp_n = (mis ? 1 : MEM_LAT + 1) + (after_done ? 1 : 0);
    nen = 0;
    n = 0;
    do begin
      step();
      n++;
      if (mem_en) begin
        chk("issue_addr", 80'(mem_addr), 80'(a));
        chk("issue_wr", 80'(mem_wr), 80'(w));
        if (w) chk("issue_wdata", 80'(mem_wdata), 80'(d_wdata));
      end
    end while (!(i_done || d_done) && n < 30);
    chk("latency", 80'(n), 80'(exp_n));
    chk("one_done", 80'(i_done & d_done), 80'd0);
    chk("d_done_winner", 80'(d_done), 80'(wd));
    chk("mem_en_count", 80'(nen), 80'(!mis));
    exp_rd = '0;
    if (!mis && !w) exp_rd = mem_m[a];
    chk("rdata", 80'(wd ? d_rdata : i_rdata), 80'(exp_rd));
    chk("err", 80'(wd ? d_err : i_err), 80'(mis ? 1'b1 : last_e));
    if (!mis) chk("hold_addr_wr", 80'({mem_addr, mem_wr}), 80'({a, w}));
    won_d = d_done;
    last_d = wd;
    if (wd) d_req = 0;
    else i_req = 0;
  endtask

  function automatic logic [15:0] rnd_addr();
    logic [15:0] a;
    a = 16'($urandom_range(0, 15)) << 1;
    if ($urandom_range(0, 1) == 1) a = a | 16'h4000;
    if ($urandom_range(0, 7) == 0) a = a | 16'h0001;
    return a;
  endfunction

  initial begin
    reset_dut();
    // fetch read
    i_req = 1; i_addr = 16'h0010;
    serve(0, won);
    step();
    // data write
    d_req = 1; d_wr = 1; d_addr = 16'h0200; d_wdata = 16'hBEEF;
    serve(0, won);
    step();
    // data read back of the written word
    d_req = 1; d_wr = 0; d_addr = 16'h0200;
    serve(0, won);
    chk("readback", 80'(won), 80'd1);
    step();
    // unaligned data access
    d_req = 1; d_wr = 0; d_addr = 16'h0203;
    serve(0, won);
    step();
    // memory error on a fetch
    err_next = 1;
    i_req = 1; i_addr = 16'h0010;
    serve(0, won);
    step();
    // reset while waiting on memory abandons the transaction
    i_req = 1; i_addr = 16'h0044;
    step();
    chk("midop_issue", 80'(mem_en), 80'd1);
    step();
    step();
    rst = 0; i_req = 0;
    step();
    chk("midop_reset_outputs", outs(), 80'd0);
    rst = 1; ret_pend = 0; last_d = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("midop_no_done", 80'({i_done, d_done, mem_en}), 80'd0);
    end
    i_req = 1; i_addr = 16'h0046;
    serve(0, won);
    // continuous tie
    reset_dut();
    i_req = 1; i_addr = 16'h0100; d_req = 1; d_wr = 0; d_addr = 16'h0102;
    for (int k = 0; k < 4; k++) begin
      serve(k != 0, won);
      chk("tie_order", 80'(won), 80'(RR ? !k[0] : 1'b1));
      i_req = 1; d_req = 1;
    end
    i_req = 0; d_req = 0;
    step();
    ad = 0;
    // randomized traffic
    for (int k = 0; k < 150; k++) begin
      if (!i_req && $urandom_range(0, 2) != 0) begin
        i_req = 1; i_addr = rnd_addr();
      end
      if (!d_req && $urandom_range(0, 2) != 0) begin
        d_req = 1; d_wr = 1'($urandom); d_addr = rnd_addr(); d_wdata = 16'($urandom);
      end
      if (!i_req && !d_req) begin
        step();
        chk("idle_quiet", 80'({i_done, d_done, mem_en}), 80'd0);
        ad = 0;
      end else begin
        serve(ad, won);
        ad = 1;
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
